// File: rtl/prga_decrypt.sv
// ARC4 keystream generation and decrypt over a length-prefixed ciphertext memory, one FSM state per cycle.
// Busy for 2+9*len cycles after en is taken; en is ignored while rdy=0, memories are single-port with 1-cycle reads.
module prga_decrypt #(
  parameter int MSG_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rdy,
  output logic [7:0]            s_addr,
  input  logic [7:0]            s_rddata,
  output logic [7:0]            s_wrdata,
  output logic                  s_wren,
  output logic [MSG_ADDR_W-1:0] ct_addr,
  input  logic [7:0]            ct_rddata,
  output logic [MSG_ADDR_W-1:0] pt_addr,
  output logic [7:0]            pt_wrdata,
  output logic                  pt_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, CAP_LEN, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, RD_PAD, CAP_PAD, WR_PT
  } state_t;

  state_t state, state_nxt;

  logic [7:0]            i, j, si, sj, pad, c;
  logic [MSG_ADDR_W-1:0] k, len;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      pad   <= '0;
      c     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CAP_LEN: begin
          len <= MSG_ADDR_W'(ct_rddata);
          i   <= '0;
          j   <= '0;
          k   <= MSG_ADDR_W'(1);
        end
        RD_I:    i <= i + 8'd1;
        CAP_I: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        CAP_J:   sj <= s_rddata;
        CAP_PAD: begin
          pad <= s_rddata;
          c   <= ct_rddata;
        end
        WR_PT:   k <= k + MSG_ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = RD_LEN;
      end
      RD_LEN: state_nxt = CAP_LEN;
      CAP_LEN: begin
        // The length byte is copied through so pt keeps the same length-prefixed layout.
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        state_nxt = (ct_rddata == 8'd0) ? IDLE : RD_I;
      end
      RD_I: begin
        s_addr    = i + 8'd1;
        state_nxt = CAP_I;
      end
      CAP_I: state_nxt = RD_J;
      RD_J: begin
        s_addr    = j;
        state_nxt = CAP_J;
      end
      CAP_J: state_nxt = WR_I;
      WR_I: begin
        s_addr    = i;
        s_wrdata  = sj;
        s_wren    = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        s_addr    = j;
        s_wrdata  = si;
        s_wren    = 1'b1;
        state_nxt = RD_PAD;
      end
      RD_PAD: begin
        s_addr    = si + sj;
        ct_addr   = k;
        state_nxt = CAP_PAD;
      end
      CAP_PAD: state_nxt = WR_PT;
      WR_PT: begin
        pt_addr   = k;
        pt_wrdata = pad ^ c;
        pt_wren   = 1'b1;
        state_nxt = (k == len) ? IDLE : RD_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Directed + randomized bench for prga_decrypt with behavioural ARC4 reference model and memory models.
module tb_prga_decrypt;

  logic       clk = 1'b0;
  logic       rst, en, rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata, pt_addr, pt_wrdata;
  logic       pt_wren;

  prga_decrypt #(.MSG_ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
  );

  always #5 clk = ~clk;

  // Memories: only this block writes them; the stimulus side preloads via ld_* arrays.
  logic [7:0] s_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ld_s [256];
  logic [7:0] ct_mem [256];
  logic       ld_go = 1'b0;
  int         s_wr_cnt = 0, pt_wr_cnt = 0, both_cnt = 0;

  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (ld_go) begin
      s_mem  <= ld_s;
      for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hAA;
    end else begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end
    if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
    if (pt_wren) pt_wr_cnt <= pt_wr_cnt + 1;
    if (s_wren && pt_wren) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0, n_fail = 0;
  logic [7:0] ms [256];
  logic [7:0] mpt [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain ARC4 PRGA over the model S, length-prefixed ciphertext.
  task automatic model_run();
    int ii, jj, n;
    logic [7:0] t;
    ii = 0; jj = 0;
    n = int'(ct_mem[0]);
    mpt[0] = ct_mem[0];
    for (int kk = 1; kk <= n; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(ms[ii])) % 256;
      t = ms[ii]; ms[ii] = ms[jj]; ms[jj] = t;
      mpt[kk] = ms[(int'(ms[ii]) + int'(ms[jj])) % 256] ^ ct_mem[kk];
    end
  endtask

  task automatic load_mems();
    @(negedge clk); ld_go = 1'b1;
    @(posedge clk); #1; ld_go = 1'b0;
  endtask

  task automatic shuffle_s();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = ld_s[x]; ld_s[x] = ld_s[r]; ld_s[r] = t;
    end
  endtask

  task automatic do_run(input string tag);
    int cyc, s0, p0, n;
    n = int'(ct_mem[0]);
    s0 = s_wr_cnt; p0 = pt_wr_cnt;
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    check({tag, " rdy_drop"}, 32'(rdy), 32'd0);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; #1;
    end while (!rdy && cyc < 4000);
    check({tag, " cycles"}, cyc, 2 + 9 * n);
    check({tag, " s_writes"}, s_wr_cnt - s0, 2 * n);
    check({tag, " pt_writes"}, pt_wr_cnt - p0, n + 1);
    for (int x = 0; x <= n; x++) check($sformatf("%s pt[%0d]", tag, x), 32'(pt_mem[x]), 32'(mpt[x]));
    for (int x = 0; x < 256; x++) check($sformatf("%s S[%0d]", tag, x), 32'(s_mem[x]), 32'(ms[x]));
  endtask

  initial begin
    logic [7:0] key [3];
    logic [7:0] ct4 [10];
    logic [7:0] pt4 [10];
    logic [7:0] t;
    int jj, s0, p0, n, found, jp;

    key = '{8'h4B, 8'h65, 8'h79};
    ct4 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt4 = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int x = 0; x < 256; x++) begin ld_s[x] = 8'(x); ct_mem[x] = 8'h00; end

    // 1: reset with en asserted
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    s0 = s_wr_cnt; p0 = pt_wr_cnt;
    @(posedge clk); #1;
    check("reset rdy", 32'(rdy), 32'd1);
    check("reset s_wren", 32'(s_wren), 32'd0);
    check("reset pt_wren", 32'(pt_wren), 32'd0);
    check("reset s_addr", 32'(s_addr), 32'd0);
    rst = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset no writes", (s_wr_cnt - s0) + (pt_wr_cnt - p0), 0);

    // 2: len = 0
    load_mems();
    for (int x = 0; x < 256; x++) ms[x] = ld_s[x];
    model_run();
    do_run("len0");

    // 3: identity S, ct = {1, FF}
    ct_mem[0] = 8'h01; ct_mem[1] = 8'hFF;
    load_mems();
    for (int x = 0; x < 256; x++) ms[x] = ld_s[x];
    model_run();
    check("ident model pt1", 32'(mpt[1]), 32'hFD);
    do_run("ident");

    // 4: KSA("Key") then decrypt known vector
    for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + int'(ld_s[x]) + int'(key[x % 3])) % 256;
      t = ld_s[x]; ld_s[x] = ld_s[jj]; ld_s[jj] = t;
    end
    for (int x = 0; x < 10; x++) ct_mem[x] = ct4[x];
    load_mems();
    for (int x = 0; x < 256; x++) ms[x] = ld_s[x];
    model_run();
    for (int x = 0; x < 10; x++) mpt[x] = pt4[x];
    do_run("key");

    // 5: len 255, random S and ct
    shuffle_s();
    ct_mem[0] = 8'd255;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom);
    load_mems();
    for (int x = 0; x < 256; x++) ms[x] = ld_s[x];
    model_run();
    do_run("long");
    check("no dual writes", both_cnt, 0);

    // 6: en held high, rst during the first WR_I, then clean rerun from partial S
    shuffle_s();
    ct_mem[0] = 8'd5;
    for (int x = 1; x < 6; x++) ct_mem[x] = 8'($urandom);
    load_mems();
    s0 = s_wr_cnt;
    @(negedge clk); en = 1'b1;
    @(posedge clk);
    found = 0;
    for (int x = 1; x <= 20 && found == 0; x++) begin
      @(negedge clk);
      if (s_wren) found = x;
      else check("abuse busy rdy", 32'(rdy), 32'd0);
    end
    check("abuse wr_i cycle", found, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0;
    check("abuse rdy", 32'(rdy), 32'd1);
    check("abuse s_wren", 32'(s_wren), 32'd0);
    check("abuse pt_wren", 32'(pt_wren), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("abuse s_writes", s_wr_cnt - s0, 1);
    // Only S[1] <= S[j] landed, with j = S[1].
    for (int x = 0; x < 256; x++) ms[x] = ld_s[x];
    jp = int'(ld_s[1]);
    ms[1] = ld_s[jp];
    for (int x = 0; x < 256; x++) check($sformatf("abuse S[%0d]", x), 32'(s_mem[x]), 32'(ms[x]));
    check("abuse pt0", 32'(pt_mem[0]), 32'd5);
    model_run();
    do_run("rerun");

    n = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
